// File: rtl/bcd_display_ctrl_pkg.sv
// Shared definitions for the front-panel display controller: FSM states,
// digit count and the 7-segment code table (active-low, {g,f,e,d,c,b,a}).
package bcd_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV_T = 2'd1,
    S_CONV_S = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 6;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd3_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-decimal nibbles cannot come out of the converter; they blank anyway.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_ctrl_b8bcd.sv
// 8-bit binary to 3-digit BCD converter (combinational shift-and-add-3).
module b8bcd (
  input  logic [7:0]  i_bin,
  output logic [11:0] o_bcd
);

  logic [19:0] w_shift;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_shift = {12'd0, i_bin};
    for (int i = 0; i < 8; i++) begin
      if (w_shift[11:8]  >= 4'd5) w_shift[11:8]  = w_shift[11:8]  + 4'd3;
      if (w_shift[15:12] >= 4'd5) w_shift[15:12] = w_shift[15:12] + 4'd3;
      if (w_shift[19:16] >= 4'd5) w_shift[19:16] = w_shift[19:16] + 4'd3;
      w_shift = w_shift << 1;
    end
    o_bcd = w_shift[19:8];
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Front-panel display controller: converts temperature and setpoint through
// one shared b8bcd, double-buffers the BCD pair and scans a 6-digit display.
module bcd_display_ctrl
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp_in,
  input  logic [7:0] setp_in,
  input  logic       upd,
  output logic       busy,
  output logic       done,
  output logic [5:0] an,
  output logic [6:0] seg
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_shadow_t;
  logic [7:0] r_shadow_s;
  bcd3_t      r_bcd_t;
  bcd3_t      r_bcd_s;
  bcd3_t      r_disp_t;
  bcd3_t      r_disp_s;
  logic       r_done;

  logic [7:0] w_conv_in;
  bcd3_t      w_conv_out;

  logic [CNT_W-1:0] r_refresh_cnt;
  logic [2:0]       r_digit_idx;
  logic [5:0]       r_an_n;
  logic [6:0]       r_seg_n;
  logic             w_tick;
  logic [2:0]       w_idx_next;
  logic [2:0]       w_slot;
  bcd3_t            w_val;
  logic [6:0]       w_slot_seg;

  // ---------------- conversion sequencer ----------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (upd) w_state_next = S_CONV_T;
      S_CONV_T: w_state_next = S_CONV_S;
      S_CONV_S: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (r_state)
      S_CONV_T: w_conv_in = r_shadow_t;
      S_CONV_S: w_conv_in = r_shadow_s;
      default:  w_conv_in = 8'd0;
    endcase
  end

  b8bcd u_conv (
    .i_bin (w_conv_in),
    .o_bcd (w_conv_out)
  );

  // Display pair is copied on a single edge so the scan never sees a mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_t <= '0;
      r_shadow_s <= '0;
      r_bcd_t    <= '0;
      r_bcd_s    <= '0;
      r_disp_t   <= '0;
      r_disp_s   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (upd) begin
            r_shadow_t <= temp_in;
            r_shadow_s <= setp_in;
          end
        end
        S_CONV_T: r_bcd_t <= w_conv_out;
        S_CONV_S: r_bcd_s <= w_conv_out;
        S_DONE: begin
          r_disp_t <= r_bcd_t;
          r_disp_s <= r_bcd_s;
        end
        default: ;
      endcase
    end
  end

  // ---------------- digit scan ----------------
  assign w_tick     = (r_refresh_cnt == CNT_LAST);
  assign w_idx_next = (r_digit_idx == IDX_LAST) ? 3'd0 : r_digit_idx + 3'd1;

  always_comb begin
    if (w_idx_next < 3'd3) begin
      w_val  = r_disp_t;
      w_slot = w_idx_next;
    end else begin
      w_val  = r_disp_s;
      w_slot = w_idx_next - 3'd3;
    end
    unique case (w_slot)
      3'd0:    w_slot_seg = bcd_to_seg(w_val.units);
      3'd1:    w_slot_seg = (w_val.hund == 4'd0 && w_val.tens == 4'd0) ? SEG_BLANK
                                                                      : bcd_to_seg(w_val.tens);
      3'd2:    w_slot_seg = (w_val.hund == 4'd0) ? SEG_BLANK : bcd_to_seg(w_val.hund);
      default: w_slot_seg = SEG_BLANK;
    endcase
  end

  // an/seg load with the index so the enable and its segments move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 3'd0;
      r_an_n        <= 6'b111110;
      r_seg_n       <= SEG_0;
    end else if (w_tick) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= w_idx_next;
      r_an_n        <= ~(6'b000001 << w_idx_next);
      r_seg_n       <= w_slot_seg;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign an   = SEG_ACTIVE_LOW ? r_an_n  : ~r_an_n;
  assign seg  = SEG_ACTIVE_LOW ? r_seg_n : ~r_seg_n;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: vector table, corner sequences
// and random traffic against a behavioural model of the panel.
module tb_bcd_display_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] temp_in;
  logic [7:0] setp_in;
  logic       upd;
  logic       busy;
  logic       done;
  logic [5:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  bcd_display_ctrl #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .temp_in (temp_in),
    .setp_in (setp_in),
    .upd     (upd),
    .busy    (busy),
    .done    (done),
    .an      (an),
    .seg     (seg)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] ref_seg(input int idx, input int t, input int s);
    int v, h, tn, u;
    v  = (idx < 3) ? t : s;
    h  = v / 100;
    tn = (v / 10) % 10;
    u  = v % 10;
    case (idx % 3)
      0:       return seg_code[u];
      1:       return (h == 0 && tn == 0) ? 7'h7F : seg_code[tn];
      default: return (h == 0) ? 7'h7F : seg_code[h];
    endcase
  endfunction

  function automatic logic [5:0] ref_an(input int idx);
    logic [5:0] one;
    one = 6'b000001 << idx;
    return ~one;
  endfunction

  int         m_cnt, m_idx, m_phase, m_cap_t, m_cap_s, m_disp_t, m_disp_s;
  logic       m_done;
  logic [6:0] m_seg;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_phase = 0; m_cap_t = 0; m_cap_s = 0;
      m_disp_t = 0; m_disp_s = 0; m_done = 1'b0;
      m_seg = ref_seg(0, 0, 0);
    end else begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 6;
        m_seg = ref_seg(m_idx, m_disp_t, m_disp_s);
      end else begin
        m_cnt++;
      end
      m_done = 1'b0;
      case (m_phase)
        0: if (upd) begin
             m_cap_t = temp_in; m_cap_s = setp_in; m_phase = 1;
           end
        1: m_phase = 2;
        2: m_phase = 3;
        default: begin
          m_disp_t = m_cap_t; m_disp_s = m_cap_s; m_done = 1'b1; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_phase != 0));
      check("done", done, m_done);
      check("an", an, ref_an(m_idx));
      check("seg", seg, m_seg);
      check("an_onehot", $countones(~an), 1);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [7:0]      t;
    logic [7:0]      s;
    logic [5:0][6:0] exp_seg;   // [5] = idx5 ... [0] = idx0
  } vec_t;

  vec_t vecs [4];

  initial begin
    int         k;
    int         done_cnt;
    logic [6:0] got [6];

    vecs[0].t = 8'd255; vecs[0].s = 8'd7;
    vecs[0].exp_seg = {7'h7F, 7'h7F, 7'h78, 7'h24, 7'h12, 7'h12};
    vecs[1].t = 8'd100; vecs[1].s = 8'd0;
    vecs[1].exp_seg = {7'h7F, 7'h7F, 7'h40, 7'h79, 7'h40, 7'h40};
    vecs[2].t = 8'd9;   vecs[2].s = 8'd45;
    vecs[2].exp_seg = {7'h7F, 7'h19, 7'h12, 7'h7F, 7'h7F, 7'h10};
    vecs[3].t = 8'd50;  vecs[3].s = 8'd205;
    vecs[3].exp_seg = {7'h24, 7'h40, 7'h12, 7'h7F, 7'h12, 7'h40};

    rst = 1'b1; upd = 1'b0; temp_in = '0; setp_in = '0;
    repeat (2) @(negedge clk);
    check("reset_an", an, 6'b111110);
    check("reset_seg", seg, 7'h40);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    foreach (vecs[v]) begin
      temp_in = vecs[v].t; setp_in = vecs[v].s; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("latency_v%0d", v), k, 3);
      repeat (6 * DIV) @(negedge clk);
      for (int j = 0; j < 6; j++) got[j] = 7'h55;
      for (int c = 0; c < 6 * DIV; c++) begin
        @(negedge clk);
        for (int j = 0; j < 6; j++) if (an == ref_an(j)) got[j] = seg;
      end
      for (int j = 0; j < 6; j++)
        check($sformatf("vec%0d_idx%0d", v, j), got[j], vecs[v].exp_seg[j]);
    end

    // upd repeated while busy: only the first request is honoured
    temp_in = 8'd33; setp_in = 8'd66; upd = 1'b1;
    done_cnt = 0;
    @(negedge clk); temp_in = 8'd44; setp_in = 8'd77;
    @(negedge clk); temp_in = 8'd88; setp_in = 8'd99;
    @(negedge clk); upd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("ignored_upd_done_cnt", done_cnt, 1);
    repeat (12 * DIV) @(negedge clk);

    // reset while converting the setpoint
    temp_in = 8'd123; setp_in = 8'd210; upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_an", an, 6'b111110);
    check("midrst_seg", seg, 7'h40);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);

    // upd held high: sequences every 4 cycles, one idle cycle between
    temp_in = 8'd17; setp_in = 8'd180; upd = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (c == 19) upd = 1'b0;
    end
    check("held_upd_done_cnt", done_cnt, 5);

    // random traffic, occasional reset
    for (int c = 0; c < 400; c++) begin
      temp_in = 8'($urandom);
      setp_in = 8'($urandom);
      upd     = ($urandom % 6 == 0);
      rst     = ($urandom % 97 == 0);
      @(negedge clk);
    end
    rst = 1'b0; upd = 1'b0;
    repeat (8 * DIV) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
